// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache. Reads hit with zero latency.
// On a miss the core stalls while a dirty victim is written back and the 4-word line is refilled.
module dcache_direct_wb #(
  parameter int INDEX_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int TAG_W = 28 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     line_q [LINES];

  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               req;
  logic               hit;

  assign offset = proc_addr[1:0];
  assign index  = proc_addr[INDEX_W+1:2];
  assign tag    = proc_addr[29:INDEX_W+2];
  assign req    = proc_read | proc_write;
  assign hit    = valid_q[index] & (tag_q[index] == tag);

  assign proc_rdata = line_q[index][{offset, 5'd0} +: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        proc_stall = req & ~hit;
        if (req && !hit) begin
          state_d = (valid_q[index] && dirty_q[index]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[index], index};
        mem_wdata  = line_q[index];
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {tag, index};
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the line store is small enough to live in flops, so it is cleared by reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
    end else if (state_q == IDLE && proc_write && hit) begin
      line_q[index][{offset, 5'd0} +: 32] <= proc_wdata;
      dirty_q[index]                      <= 1'b1;
    end else if (state_q == ALLOCATE && mem_ready) begin
      line_q[index]  <= mem_rdata;
      tag_q[index]   <= tag;
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end
  end

endmodule
